// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if
//   Handshake and result bundle between the main control FSM (master) and
//   the MULT/DIV sequencer (slave).
//   start/op/a/b/cancel : request side, driven by the master
//   busy/done/div_zero  : status, driven by the sequencer
//   hi/lo               : HI/LO register contents, driven by the sequencer
interface mult_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Multi-cycle sequencer for the signed MULT/DIV unit that owns HI/LO.
//   A one-cycle start latches the operand signs and magnitudes, then WIDTH
//   shift-add (MULT) or restoring (DIV) steps run on the magnitudes, a FIX
//   cycle applies the sign correction, writes HI/LO and pulses done.
// Ports
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears all state and outputs
//   bus   : mult_div_ctrl_if.slave (start/op/a/b/cancel in,
//           busy/done/div_zero/hi/lo out, all outputs registered)
// Configuration
//   MULT_DIV_DIV0_EXC_EN : when defined, a divide by zero is caught in PREP,
//   pulses done+div_zero and leaves HI/LO untouched. When undefined the
//   divide runs its full length and div_zero is tied low.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  mult_div_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Two's complement negate of a WIDTH-bit value
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? f_neg(v) : v;
  endfunction

  state_t             r_state;
  logic               r_op;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MULT_DIV_DIV0_EXC_EN
  logic               r_div_zero;
`endif

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // One iteration step for both operations.
  // MULT: r_acc = {partial product, remaining multiplier}; add the
  //   multiplicand on the multiplier LSB, then shift the pair right.
  // DIV: r_acc = {remainder, quotient}; the trial subtract uses the bit
  //   shifted out of the remainder so nothing is lost on the left shift.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                  (r_acc[0] ? {1'b0, r_mag_b} : {(WIDTH+1){1'b0}});
    w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mag_b};
    if (w_div_trial[WIDTH]) begin
      w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    if (r_sa ^ r_sb) begin
      w_prod = ~r_acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_prod = r_acc;
    end
    if (r_op) begin
      w_fix_lo = (r_sa ^ r_sb) ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      w_fix_hi = r_sa ? f_neg(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered status and HI/LO outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_op       <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_mag_a    <= {WIDTH{1'b0}};
      r_mag_b    <= {WIDTH{1'b0}};
      r_acc      <= {(2*WIDTH){1'b0}};
      r_cnt      <= {CNT_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
`ifdef MULT_DIV_DIV0_EXC_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
`ifdef MULT_DIV_DIV0_EXC_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.cancel) begin
            r_state <= ST_PREP;
            r_busy  <= 1'b1;
            r_op    <= bus.op;
            r_sa    <= bus.a[WIDTH-1];
            r_sb    <= bus.b[WIDTH-1];
            r_mag_a <= f_mag(bus.a);
            r_mag_b <= f_mag(bus.b);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_PREP: begin
          if (bus.cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`ifdef MULT_DIV_DIV0_EXC_EN
          end else if (r_op && (r_mag_b == {WIDTH{1'b0}})) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
`endif
          end else begin
            r_state <= ST_ITER;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_acc   <= {{WIDTH{1'b0}}, r_mag_a};
          end
        end
        ST_ITER: begin
          if (bus.cancel) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= r_op ? w_div_next : w_mul_next;
            if (r_cnt == {CNT_W{1'b0}}) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!bus.cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end else begin
            r_done <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
`ifdef MULT_DIV_DIV0_EXC_EN
  assign bus.div_zero = r_div_zero;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl
//   Directed bench for mult_div_ctrl: hand-computed results, latency and
//   busy-length checks, back-to-back issue, divide by zero (both builds),
//   cancel, start-while-busy and asynchronous reset mid-operation.
module tb_mult_div_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mult_div_ctrl_if #(.WIDTH(32)) bus ();

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Issue one operation now, wait (bounded) for done and check everything
  task automatic do_op(input string tag, input logic op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input int exp_lat, input logic exp_dz);
    int lat;
    int bcyc;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat  = 0;
    bcyc = bus.busy ? 1 : 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && bus.busy) bcyc++;
    end
    check_val({tag, "_done"}, 64'(bus.done), 64'd1);
    check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_busycyc"}, 64'(bcyc), 64'(exp_lat));
    check_val({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check_val({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
    check_val({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check_val({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
  endtask

  initial begin
    int n_done;
    logic [31:0] hi_at_done;
    logic [31:0] lo_at_done;
    n_checks   = 0;
    n_errors   = 0;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.cancel = 1'b0;
    rst_n      = 1'b0;
    #22;
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_dz", 64'(bus.div_zero), 64'd0);
    check_val("rst_hi", 64'(bus.hi), 64'd0);
    check_val("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul_6_m7", 1'b0, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 34, 1'b0);
    // Back-to-back: each start is driven in the done cycle of the previous op
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 1'b0);
    do_op("mul_m3_m5", 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 34, 1'b0);

    // Preload HI=0x11, LO=0x22 via 0x451 / 0x20
    do_op("preload", 1'b1, 32'h0000_0451, 32'h0000_0020, 32'h11, 32'h22, 34, 1'b0);
`ifdef MULT_DIV_DIV0_EXC_EN
    do_op("div0_5", 1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1'b1);
    do_op("div0_m7", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'h11, 32'h22, 1, 1'b1);
`else
    do_op("div0_5", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 34, 1'b0);
    do_op("div0_m7", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'h0000_0001, 34, 1'b0);
`endif

    do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 34, 1'b0);
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1'b0);

    // Cancel at iteration 10: HI/LO must keep 0 / 0x80000000
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check_val("cancel_busy", 64'(bus.busy), 64'd0);
    check_val("cancel_done", 64'(bus.done), 64'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check_val("cancel_ndone", 64'(n_done), 64'd0);
    check_val("cancel_hi", 64'(bus.hi), 64'd0);
    check_val("cancel_lo", 64'(bus.lo), 64'h8000_0000);

    // start pulsed while busy must be ignored and not queued
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'hFFFF_FFFD;
    bus.b     = 32'hFFFF_FFFB;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    n_done     = 0;
    hi_at_done = 32'hDEAD_BEEF;
    lo_at_done = 32'hDEAD_BEEF;
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        n_done++;
        hi_at_done = bus.hi;
        lo_at_done = bus.lo;
      end
    end
    check_val("busystart_ndone", 64'(n_done), 64'd1);
    check_val("busystart_hi", 64'(hi_at_done), 64'd0);
    check_val("busystart_lo", 64'(lo_at_done), 64'd15);

    // Asynchronous reset in the middle of ITER, between clock edges
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check_val("prerst_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", 64'(bus.busy), 64'd0);
    check_val("arst_done", 64'(bus.done), 64'd0);
    check_val("arst_hi", 64'(bus.hi), 64'd0);
    check_val("arst_lo", 64'(bus.lo), 64'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("mul_3_4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 34, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
